cpc_ram_mapper: RTL and testbench

Parametrised CPC expansion RAM mapper and the next generation of the 1MB card logic. It decodes gate-array style bank-select and ROM-control port writes and tracks memory-write cycles with a small state machine. It maps CPU accesses onto 2^BLOCK_BITS 64KB blocks spread over 2^CS_BITS SRAM chips. It sits between the CPC expansion bus and the SRAM array, and drives chip selects, upper SRAM address lines, OE/WE and RAMDIS.

---
 rtl/cpc_ram_mapper.sv | 118 +++++++++++
 tb/tb_cpc_ram_mapper.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_ram_mapper.sv
// CPC expansion RAM mapper: port-write decode, bank/page mapping onto 2^CS_BITS SRAM chips, write-strobe FSM.
// Optional build macro RESET_RESYNC_EN adds a two-flop release synchroniser on reset_b.
module cpc_ram_mapper #(
   parameter int BLOCK_BITS = 4,
   parameter int CS_BITS    = 1
) (
   input  logic                           clk,
   input  logic                           reset_b,
   input  logic                           mreq_b,
   input  logic                           iorq_b,
   input  logic                           rd_b,
   input  logic                           wr_b,
   input  logic                           rfsh_b,
   input  logic                           adr15,
   input  logic                           adr14,
   input  logic [2:0]                     adr_port,
   input  logic [7:0]                     data,
   output logic [(1<<CS_BITS)-1:0]        ramcs_b,
   output logic [BLOCK_BITS-CS_BITS+1:0]  ramadrhi,
   output logic                           ramoe_b,
   output logic                           ramwe_b,
   output wire                            ramdis
);

   localparam int NCS = 1 << CS_BITS;
   localparam int AW  = BLOCK_BITS - CS_BITS + 2;

   typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_END} wr_state_t;

   logic          rst_n;
   logic [2:0]    cfg;
   logic [5:0]    blk;
   logic          urom_dis, lrom_dis, armed;
   wr_state_t     state;
   logic [AW-1:0] adr_hold, adr_now;
   logic [1:0]    page;
   logic [5:0]    chip;
   logic          port_wr, mapped, populated, rom_shadow, claim;

`ifdef RESET_RESYNC_EN
   // Assertion stays asynchronous; release is delayed two clocks.
   logic [1:0] rst_sync;
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];
`else
   assign rst_n = reset_b;
`endif

   assign port_wr = !iorq_b && !wr_b && !adr15 && data[7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg      <= 3'd0;
         blk      <= 6'd0;
         urom_dis <= 1'b0;
         lrom_dis <= 1'b0;
         armed    <= 1'b1;
      end else if (iorq_b) begin
         armed <= 1'b1;
      end else if (port_wr && armed) begin
         // One capture per I/O cycle, however long the OUT is held.
         armed <= 1'b0;
         if (data[6]) begin
            cfg <= data[2:0];
            blk <= {~adr_port, data[5:3]};
         end else begin
            {urom_dis, lrom_dis} <= data[3:2];
         end
      end
   end

   always_comb begin
      mapped = 1'b0;
      page   = 2'b00;
      case (cfg)
         3'd1, 3'd3: begin mapped = adr15 && adr14; page = 2'b11; end
         3'd2:       begin mapped = 1'b1;           page = {adr15, adr14}; end
         3'd4, 3'd5, 3'd6, 3'd7:
                     begin mapped = !adr15 && adr14; page = cfg[1:0]; end
         default: ;
      endcase
   end

   assign populated  = (blk >> BLOCK_BITS) == 6'd0;
   assign rom_shadow = !rd_b && ((adr15 && adr14 && !urom_dis) || (!adr15 && !adr14 && !lrom_dis));
   assign claim      = !mreq_b && rfsh_b && mapped && populated && !rom_shadow;
   assign chip       = blk >> (BLOCK_BITS - CS_BITS);
   assign adr_now    = {blk[BLOCK_BITS-CS_BITS-1:0], page};

   assign ramcs_b  = claim ? ~(NCS'(1) << chip) : '1;
   assign ramadrhi = claim ? adr_now : adr_hold;
   assign ramoe_b  = claim ? rd_b : 1'b1;
   assign ramwe_b  = !(state == S_T2 && !wr_b && claim);
   assign ramdis   = claim ? 1'b1 : 1'bz;

   // Upper address lines keep the last claimed page between accesses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     adr_hold <= '0;
      else if (claim) adr_hold <= adr_now;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else if (mreq_b) state <= S_IDLE;
      else begin
         case (state)
            S_IDLE: if (rd_b) state <= S_T1;
            S_T1:   state <= S_T2;
            S_T2:   if (wr_b) state <= S_END;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpc_ram_mapper.sv
// Self-checking bench for cpc_ram_mapper: directed vector table, hand sequences, and randomized traffic vs. a model.
module tb_cpc_ram_mapper;

   logic       clk = 1'b0;
   logic       reset_b, mreq_b, iorq_b, rd_b, wr_b, rfsh_b, adr15, adr14;
   logic [2:0] adr_port;
   logic [7:0] data;
   logic [1:0] ramcs_b;
   logic [4:0] ramadrhi;
   logic       ramoe_b, ramwe_b;
   wire        ramdis;

   pulldown (ramdis);

   cpc_ram_mapper #(.BLOCK_BITS(4), .CS_BITS(1)) dut (
      .clk(clk), .reset_b(reset_b), .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b),
      .wr_b(wr_b), .rfsh_b(rfsh_b), .adr15(adr15), .adr14(adr14), .adr_port(adr_port),
      .data(data), .ramcs_b(ramcs_b), .ramadrhi(ramadrhi), .ramoe_b(ramoe_b),
      .ramwe_b(ramwe_b), .ramdis(ramdis)
   );

   always #5 clk = ~clk;

   int passed = 0, total = 0;
   // Model state: what the card should hold after the OUTs issued so far.
   int m_cfg = 0, m_blk = 0, m_hold = 0;
   bit m_urom = 0, m_lrom = 0;

   typedef struct {
      logic [2:0] ap;
      logic [7:0] d;
      bit         a15, a14, wr;
      logic [1:0] cs;
      logic [4:0] ahi;
      bit         dis;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic model_reset();
      m_cfg = 0; m_blk = 0; m_hold = 0; m_urom = 0; m_lrom = 0;
   endtask

   task automatic model_out(input int a, input int d);
      if ((d & 128) == 0) return;
      if ((d & 64) != 0) begin
         m_cfg = d % 8;
         m_blk = (7 - a) * 8 + (d / 8) % 8;
      end else begin
         m_urom = ((d / 8) % 2) == 1;
         m_lrom = ((d / 4) % 2) == 1;
      end
   endtask

   // Expected decode from the address map, ROM rules and population rule.
   task automatic expect_acc(input bit a15, input bit a14, input bit rd, input bit rfsh,
                             output bit claim, output int cs, output int ahi);
      int addr, page;
      bit mapped, rom;
      addr = a15 * 32768 + a14 * 16384;
      mapped = 0; page = 0;
      if (m_cfg == 1 || m_cfg == 3) begin mapped = addr >= 49152; page = 3; end
      else if (m_cfg == 2) begin mapped = 1; page = addr / 16384; end
      else if (m_cfg >= 4) begin mapped = addr >= 16384 && addr < 32768; page = m_cfg - 4; end
      rom = rd && ((addr >= 49152 && !m_urom) || (addr < 16384 && !m_lrom));
      claim = mapped && rfsh && (m_blk < 16) && !rom;
      cs = claim ? 3 - (1 << (m_blk / 8)) : 3;
      ahi = (m_blk % 8) * 4 + page;
   endtask

   task automatic do_out(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      iorq_b = 0; wr_b = 0; adr15 = 0; adr_port = a; data = d;
      @(negedge clk);
      iorq_b = 1; wr_b = 1;
      model_out(int'(a), int'(d));
   endtask

   task automatic do_read(input bit a15v, input bit a14v, input bit rfsh);
      bit claim; int cs, ahi;
      @(negedge clk);
      adr15 = a15v; adr14 = a14v; mreq_b = 0; rd_b = 0; rfsh_b = rfsh;
      #1;
      expect_acc(a15v, a14v, 1'b1, rfsh, claim, cs, ahi);
      chk("rd_cs", int'(ramcs_b), cs);
      chk("rd_adrhi", int'(ramadrhi), claim ? ahi : m_hold);
      chk("rd_oe", int'(ramoe_b), claim ? 0 : 1);
      chk("rd_dis", int'(ramdis), int'(claim));
      chk("rd_we", int'(ramwe_b), 1);
      @(negedge clk);
      mreq_b = 1; rd_b = 1; rfsh_b = 1;
      if (claim) m_hold = ahi;
   endtask

   // Z80-like write: strobe low from T1, must only reach SRAM once in T2.
   task automatic do_write(input bit a15v, input bit a14v);
      bit claim; int cs, ahi;
      @(negedge clk);
      adr15 = a15v; adr14 = a14v; mreq_b = 0; rd_b = 1; wr_b = 1; rfsh_b = 1;
      #1;
      expect_acc(a15v, a14v, 1'b0, 1'b1, claim, cs, ahi);
      chk("wr_cs", int'(ramcs_b), cs);
      chk("wr_adrhi", int'(ramadrhi), claim ? ahi : m_hold);
      chk("wr_dis", int'(ramdis), int'(claim));
      chk("wr_we_idle", int'(ramwe_b), 1);
      @(negedge clk);
      wr_b = 0;
      #1 chk("wr_we_t1", int'(ramwe_b), 1);
      @(negedge clk);
      #1 chk("wr_we_t2", int'(ramwe_b), claim ? 0 : 1);
      wr_b = 1;
      #1 chk("wr_we_rise", int'(ramwe_b), 1);
      @(negedge clk);
      mreq_b = 1;
      if (claim) m_hold = ahi;
      @(negedge clk);
   endtask

   vec_t vt[13];

   initial begin
      vt[0]  = '{3'b111, 8'hC4, 0, 1, 1, 2'b10, 5'b00000, 1};
      vt[1]  = '{3'b110, 8'hD6, 0, 1, 1, 2'b01, 5'b01010, 1};
      vt[2]  = '{3'b101, 8'hC4, 0, 1, 1, 2'b11, 5'b00000, 0};
      vt[3]  = '{3'b111, 8'hC1, 1, 1, 0, 2'b11, 5'b00000, 0};
      vt[4]  = '{3'b111, 8'h8C, 1, 1, 0, 2'b10, 5'b00011, 1};
      vt[5]  = '{3'b111, 8'hC2, 0, 0, 0, 2'b10, 5'b00000, 1};
      vt[6]  = '{3'b111, 8'h80, 0, 0, 0, 2'b11, 5'b00000, 0};
      vt[7]  = '{3'b111, 8'hC2, 0, 0, 1, 2'b10, 5'b00000, 1};
      vt[8]  = '{3'b000, 8'hC7, 0, 1, 0, 2'b11, 5'b00000, 0};
      vt[9]  = '{3'b111, 8'hFF, 0, 1, 1, 2'b10, 5'b11111, 1};
      vt[10] = '{3'b111, 8'hCC, 1, 0, 1, 2'b11, 5'b00000, 0};
      vt[11] = '{3'b110, 8'hC3, 1, 1, 1, 2'b01, 5'b00011, 1};
      vt[12] = '{3'b111, 8'h44, 1, 1, 1, 2'b01, 5'b00011, 1};

      reset_b = 0; mreq_b = 0; iorq_b = 1; rd_b = 0; wr_b = 1; rfsh_b = 1;
      adr15 = 0; adr14 = 1; adr_port = 3'b000; data = 8'h00;
      #1;
      chk("rst_cs", int'(ramcs_b), 3);
      chk("rst_oe", int'(ramoe_b), 1);
      chk("rst_we", int'(ramwe_b), 1);
      chk("rst_dis", int'(ramdis), 0);
      chk("rst_adrhi", int'(ramadrhi), 0);
      repeat (2) @(negedge clk);
      mreq_b = 1; rd_b = 1;
      reset_b = 1;
      repeat (3) @(negedge clk);
      do_read(0, 1, 1);

      // Directed vectors: expected values are table constants.
      foreach (vt[i]) begin
         do_out(vt[i].ap, vt[i].d);
         @(negedge clk);
         adr15 = vt[i].a15; adr14 = vt[i].a14; mreq_b = 0; rfsh_b = 1;
         rd_b = vt[i].wr; wr_b = !vt[i].wr;
         #1;
         chk($sformatf("vec%0d_cs", i), int'(ramcs_b), int'(vt[i].cs));
         chk($sformatf("vec%0d_dis", i), int'(ramdis), int'(vt[i].dis));
         chk($sformatf("vec%0d_oe", i), int'(ramoe_b), (vt[i].dis && !vt[i].wr) ? 0 : 1);
         chk($sformatf("vec%0d_we", i), int'(ramwe_b), 1);
         if (vt[i].dis) chk($sformatf("vec%0d_adrhi", i), int'(ramadrhi), int'(vt[i].ahi));
         @(negedge clk);
         mreq_b = 1; rd_b = 1; wr_b = 1;
         if (vt[i].dis) m_hold = int'(vt[i].ahi);
      end

      // Full write cycles, including the T1 hold-off.
      do_out(3'b111, 8'hC4);
      do_write(0, 1);
      do_out(3'b110, 8'hD6);
      do_write(0, 1);
      do_out(3'b101, 8'hC4);
      do_write(0, 1);

      // OUT held over several clocks with data changing must capture only once.
      @(negedge clk);
      iorq_b = 0; wr_b = 0; adr15 = 0; adr_port = 3'b111; data = 8'hC4;
      @(negedge clk);
      data = 8'hC5;
      repeat (2) @(negedge clk);
      iorq_b = 1; wr_b = 1;
      model_out(7, 'hC4);
      do_read(0, 1, 1);
      do_out(3'b111, 8'hC5);
      do_read(0, 1, 1);

      // Reset asserted during T2 drops the write strobe immediately.
      do_out(3'b111, 8'hC4);
      @(negedge clk);
      adr15 = 0; adr14 = 1; mreq_b = 0; rd_b = 1; wr_b = 1;
      @(negedge clk);
      wr_b = 0;
      @(negedge clk);
      #1 chk("mid_we_t2", int'(ramwe_b), 0);
      reset_b = 0;
      #1;
      chk("mid_we_rst", int'(ramwe_b), 1);
      chk("mid_cs_rst", int'(ramcs_b), 3);
      chk("mid_adrhi_rst", int'(ramadrhi), 0);
      model_reset();
      @(negedge clk);
      mreq_b = 1; wr_b = 1;
      @(negedge clk);
      reset_b = 1;
`ifdef RESET_RESYNC_EN
      iorq_b = 0; wr_b = 0; adr15 = 0; adr_port = 3'b111; data = 8'hC4;
      @(negedge clk);
      iorq_b = 1; wr_b = 1;
      repeat (2) @(negedge clk);
      do_read(0, 1, 1);
`else
      @(negedge clk);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 200; n++) begin
         logic [2:0] ap;
         logic [7:0] d;
         ap = ($urandom_range(0, 1) == 1) ? {2'b11, 1'($urandom_range(0, 1))} : 3'($urandom);
         d = 8'($urandom);
         if ($urandom_range(0, 7) != 0) d[7] = 1'b1;
         do_out(ap, d);
         if ($urandom_range(0, 1) == 1)
            do_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else
            do_read(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
